// File: rtl/pn_bert_checker_pkg.sv
// Shared state encoding and LFSR helper functions for the PN BERT checker.
// Helpers operate on a fixed 32-bit vector, so LFSR_W may not exceed 32.
package pn_bert_checker_pkg;

  localparam int unsigned LFSR_W_DEF = 24;
  localparam int unsigned FN_W       = 32;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } bertState_t;

  // Ones in every stage position below len.
  function automatic logic [FN_W-1:0] lenMask(input logic [4:0] len);
    lenMask = (FN_W'(1) << len) - FN_W'(1);
  endfunction

  function automatic logic predictBit(input logic [FN_W-1:0] tapped);
    predictBit = ^tapped;
  endfunction

endpackage

// File: rtl/bert_sync_lfsr.sv
// Receive LFSR: state register, length-masked taps, predicted bit and the
// selection between self-synchronising (received bit) and free-running feedback.
module bert_sync_lfsr
  import pn_bert_checker_pkg::*;
#(
  parameter int unsigned LFSR_W = LFSR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shiftEn,
  input  logic              freeRun,
  input  logic              flipFb,
  input  logic              dataBit,
  input  logic [LFSR_W-1:0] poly,
  input  logic [4:0]        polyLength,
  output logic              predict
);

  logic [LFSR_W-1:0] s;
  logic [FN_W-1:0]   sExt;
  logic [FN_W-1:0]   polyExt;
  logic              shiftIn;

  always_comb begin
    sExt                 = '0;
    sExt[LFSR_W-1:0]     = s;
    polyExt              = '0;
    polyExt[LFSR_W-1:0]  = poly;
    predict              = predictBit(sExt & polyExt & lenMask(polyLength));
    // An inverted lock keeps the register holding the inverted sequence.
    shiftIn              = freeRun ? (predict ^ flipFb) : dataBit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s <= '0;
    end else if (shiftEn) begin
      s <= {s[LFSR_W-2:0], shiftIn};
    end
  end

endmodule

// File: rtl/pn_bert_checker.sv
// PN BERT checker: self-synchronising search/verify/lock FSM with bit, error and
// windowed error counters. Optional BERT_INVERT_DETECT_EN adds inverted-stream lock.
module pn_bert_checker
  import pn_bert_checker_pkg::*;
#(
  parameter int unsigned LFSR_W = LFSR_W_DEF,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned WIN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bitEn,
  input  logic              dataBit,
  input  logic [LFSR_W-1:0] poly,
  input  logic [4:0]        polyLength,
  input  logic [WIN_W-1:0]  syncCount,
  input  logic [WIN_W-1:0]  winLength,
  input  logic [WIN_W-1:0]  lossThresh,
  input  logic              restart,
  output logic              locked,
  output logic [CNT_W-1:0]  bitCount,
  output logic [CNT_W-1:0]  errCount,
  output logic [WIN_W-1:0]  winErrs,
`ifdef BERT_INVERT_DETECT_EN
  output logic              inverted,
`endif
  output logic              winDone
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  bertState_t       state;
  logic [4:0]       fillCnt;
  logic [WIN_W-1:0] matchCnt, winCnt, winErrCnt;
  logic [WIN_W-1:0] syncTarget, winTarget, matchNext, winNext, winErrNext;
  logic             predict, expBit, mismatch, invFlag;

`ifdef BERT_INVERT_DETECT_EN
  logic [WIN_W-1:0] invCnt, invNext;
  logic             inv;
  assign inverted = inv;
  assign invFlag  = inv;
  assign invNext  = invCnt + WIN_ONE;
`else
  assign invFlag  = 1'b0;
`endif

  always_comb begin
    syncTarget = (syncCount == '0) ? WIN_ONE : syncCount;
    winTarget  = (winLength == '0) ? WIN_ONE : winLength;
    expBit     = predict ^ invFlag;
    mismatch   = dataBit != expBit;
    matchNext  = matchCnt + WIN_ONE;
    winNext    = winCnt + WIN_ONE;
    winErrNext = (mismatch && winErrCnt != '1) ? winErrCnt + WIN_ONE : winErrCnt;
  end

  bert_sync_lfsr #(.LFSR_W(LFSR_W)) uLfsr (
    .clk        (clk),
    .reset      (reset),
    .shiftEn    (bitEn && !restart),
    .freeRun    (state == LOCKED),
    .flipFb     (invFlag),
    .dataBit    (dataBit),
    .poly       (poly),
    .polyLength (polyLength),
    .predict    (predict)
  );

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      fillCnt   <= '0;
      matchCnt  <= '0;
      winCnt    <= '0;
      winErrCnt <= '0;
      bitCount  <= '0;
      errCount  <= '0;
      winErrs   <= '0;
      winDone   <= 1'b0;
`ifdef BERT_INVERT_DETECT_EN
      invCnt    <= '0;
      inv       <= 1'b0;
`endif
    end else begin
      winDone <= 1'b0;
      if (bitEn) begin
        case (state)
          SEARCH: begin
            if (fillCnt + 5'd1 >= polyLength) begin
              state    <= VERIFY;
              fillCnt  <= '0;
              matchCnt <= '0;
`ifdef BERT_INVERT_DETECT_EN
              invCnt   <= '0;
`endif
            end else begin
              fillCnt <= fillCnt + 5'd1;
            end
          end
          VERIFY: begin
`ifdef BERT_INVERT_DETECT_EN
            // Two run counters; breaking an established run restarts the search.
            if (!mismatch) begin
              invCnt <= '0;
              if (invCnt != '0) begin
                state   <= SEARCH;
                fillCnt <= '0;
              end else if (matchNext >= syncTarget) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                matchCnt <= matchNext;
              end
            end else begin
              matchCnt <= '0;
              if (matchCnt != '0) begin
                state   <= SEARCH;
                fillCnt <= '0;
              end else if (invNext >= syncTarget) begin
                state  <= LOCKED;
                locked <= 1'b1;
                inv    <= 1'b1;
              end else begin
                invCnt <= invNext;
              end
            end
`else
            if (mismatch) begin
              state   <= SEARCH;
              fillCnt <= '0;
            end else if (matchNext >= syncTarget) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              matchCnt <= matchNext;
            end
`endif
          end
          LOCKED: begin
            if (bitCount != '1) bitCount <= bitCount + CNT_ONE;
            if (mismatch && errCount != '1) errCount <= errCount + CNT_ONE;
            if (winNext >= winTarget) begin
              winErrs   <= winErrNext;
              winDone   <= 1'b1;
              winCnt    <= '0;
              winErrCnt <= '0;
              if (winErrNext > lossThresh) begin
                state   <= SEARCH;
                fillCnt <= '0;
                locked  <= 1'b0;
`ifdef BERT_INVERT_DETECT_EN
                inv     <= 1'b0;
`endif
              end
            end else begin
              winCnt    <= winNext;
              winErrCnt <= winErrNext;
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pn_bert_checker.md
Name: pn_bert_checker

Overview:
- Receive-side BERT stage directly downstream of the PN generator/PCM encoder.
- Consumes a serial NRZ bit stream qualified by a bit-enable and self-synchronises a local LFSR to it.
- Once synchronised, free-runs the LFSR, compares each bit, and counts bits and errors.
- Declares loss of sync from windowed error density; exposes counters and lock status to register logic.

Parameters:
- LFSR_W, 24, maximum polynomial length; matches the generator tap width.
- CNT_W, 32, width of the bit and error counters.
- WIN_W, 16, width of the window-length and threshold fields.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- bitEn  in  1  one-cycle strobe; dataBit is valid when high.
- dataBit  in  1  received NRZ bit.
- poly  in  LFSR_W  tap mask; bit k = tap on stage k+1; already mirrored by the caller.
- polyLength  in  5  active LFSR length, 2..LFSR_W.
- syncCount  in  WIN_W  consecutive correct predictions required to lock.
- winLength  in  WIN_W  bits per error window (0 treated as 1).
- lossThresh  in  WIN_W  window errors strictly above this drop lock.
- restart  in  1  one-cycle strobe: clear counters, return to SEARCH.
- locked  out  1  high in LOCKED.
- bitCount  out  CNT_W  bits compared while LOCKED.
- errCount  out  CNT_W  mismatches while LOCKED.
- winErrs  out  WIN_W  error total of the last completed window.
- winDone  out  1  one-cycle pulse when winErrs updates.

Behaviour:
- State register s[LFSR_W-1:0]. Only bits below polyLength are used; poly is ANDed with the length mask.
- Predicted bit p = XOR-reduce(s & maskedPoly), computed combinationally.
- All state changes occur only on cycles where bitEn=1, except reset and restart.
- States: SEARCH, VERIFY, LOCKED.
- SEARCH:
  - s <= {s[LFSR_W-2:0], dataBit}; fill counter increments.
  - After polyLength bits are loaded, go to VERIFY with the match counter at 0.
- VERIFY:
  - s shifts in dataBit (self-synchronising).
  - If p==dataBit, increment the match counter; otherwise return to SEARCH with fill counter 0.
  - When the match counter reaches syncCount (0 treated as 1), go to LOCKED. Counters are not touched.
- LOCKED:
  - s <= {s[LFSR_W-2:0], p} (free-run, immune to input errors).
  - bitCount increments; errCount increments when p!=dataBit.
  - Window counter increments; window error count increments on mismatch.
  - On the last bit of a window: winErrs <= window errors including this bit; winDone pulses the next cycle; window counters clear.
  - If the window errors exceed lossThresh, go to SEARCH next cycle with fill counter 0 and counters held.
- Counters saturate at all-ones; they never wrap. The window error counter saturates at WIN_W all-ones.
- Latency: locked rises the cycle after the bitEn that completes VERIFY. Counters update one cycle after their bitEn.
- restart:
  - Clears bitCount, errCount, winErrs, and the window/fill/match counters; state <= SEARCH; s is preserved.
  - restart wins over a simultaneous bitEn, which is discarded.
- Reset: s=0, state=SEARCH, locked=0, bitCount=0, errCount=0, winErrs=0, winDone=0.
- Changing poly or polyLength mid-operation has no automatic effect; software issues restart.
- All-zero LFSR in LOCKED: the generator never produces it, so it is not special-cased.

Optional Feature:
- Macro BERT_INVERT_DETECT_EN.
- With the macro:
  - In VERIFY, a separate counter tracks consecutive p!=dataBit.
  - Reaching syncCount locks with an output `inverted`=1, and LOCKED compares against ~p.
  - `inverted` clears on reset, restart, and loss of sync.
- Without the macro: the port is absent, and any mismatch in VERIFY returns to SEARCH.

Decomposition:
- Shared package/include holds: state encodings (SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2), the LFSR_W default, the length-mask function, and the XOR-reduce predict function.
- One sub-module is natural: bert_sync_lfsr (state register, masking, predict, shift-select input). The FSM and counters stay in the top level.

Test Plan:
- PN15 (poly 24'h006000, length 15) clean stream, syncCount=32, bitEn every cycle:
  - locked=1 after exactly 15+32 strobes.
  - errCount=0 after 10000 bits; bitCount=10000.
- Locked PN15 with one bit flipped per 1000, winLength=1000, lossThresh=10:
  - locked stays 1; errCount increments by 1 per flip.
  - winErrs=1 with winDone every 1000 bits.
- Same setup with 11 flips inside one window: locked drops the cycle after the window-end bitEn; winErrs=11; re-locks after 15+32 clean bits.
- Random data for 5000 bits: locked never asserts; bitCount=0.
- restart asserted together with bitEn while LOCKED: next cycle locked=0, counters=0, and that bit is not counted.
- Counter saturation with CNT_W forced to 4: errCount holds 15 after 20 errors.
- With BERT_INVERT_DETECT_EN, an inverted PN15 stream: inverted=1, locked=1, errCount=0.
